// File: rtl/poly_osc_pkg.sv
// Shared constants, waveform mode encoding and the reusable shaping function
// for the synth oscillators.
package poly_osc_pkg;

  localparam int SYNTH_PHASE_ACC_BITS = 32;
  localparam int SYNTH_WIDTH          = 24;

  // Shaping is done on left-justified words so one function serves any width
  // up to this size; callers keep the top WIDTH bits of the result.
  localparam int SHAPE_BITS = 64;

  typedef enum logic [1:0] {
    PULSE = 2'd0,
    SAW   = 2'd1,
    TRI   = 2'd2,
    MUTE  = 2'd3
  } osc_mode_t;

  localparam logic [SYNTH_WIDTH-1:0] OSC_DEFAULT_DUTY = {1'b1, {(SYNTH_WIDTH-1){1'b0}}};

  function automatic logic [SHAPE_BITS-1:0] shape_sample(
    input logic [SHAPE_BITS-1:0] p,
    input osc_mode_t             mode,
    input logic [SHAPE_BITS-1:0] duty
  );
    logic [SHAPE_BITS-1:0] tri_fold;
    logic [SHAPE_BITS-1:0] result;
    result   = '0;
    tri_fold = p << 1;
    if (p[SHAPE_BITS-1]) begin
      tri_fold = ~tri_fold;
    end
    case (mode)
      PULSE: begin
        if (p < duty) begin
          result = {1'b0, {(SHAPE_BITS-1){1'b1}}};
        end else begin
          result = {1'b1, {(SHAPE_BITS-1){1'b0}}};
        end
      end
      SAW:     result = {~p[SHAPE_BITS-1], p[SHAPE_BITS-2:0]};
      TRI:     result = {~tri_fold[SHAPE_BITS-1], tri_fold[SHAPE_BITS-2:0]};
      default: result = '0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/poly_osc_pipeline_ar.sv
// Fixed-latency delay line with asynchronous active-high reset to zero.
module pipeline_ar #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign q = d;
    end else begin : g_delay
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] q_stage;
        if (gi == 0) begin : g_head
          always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
              q_stage <= '0;
            end else begin
              q_stage <= d;
            end
          end
        end else begin : g_tail
          always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
              q_stage <= '0;
            end else begin
              q_stage <= g_stage[gi-1].q_stage;
            end
          end
        end
      end
      assign q = g_stage[DEPTH-1].q_stage;
    end
  endgenerate

endmodule

// File: rtl/poly_osc.sv
// Multi-waveform oscillator: one phase accumulator feeding pulse/saw/tri/mute
// shaping, with settings that only change at a period boundary.
module poly_osc
  import poly_osc_pkg::*;
#(
  parameter int ACC_BITS   = SYNTH_PHASE_ACC_BITS,
  parameter int WIDTH      = SYNTH_WIDTH,
  parameter int PIPE_DEPTH = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    tick_in,
  input  logic [ACC_BITS-1:0]     phase_incr_in,
  input  osc_mode_t               mode_in,
  input  logic [WIDTH-1:0]        duty_in,
  input  logic                    sync_in,
  output logic signed [WIDTH-1:0] val_out,
  output logic                    wrap_out
);

  localparam logic [WIDTH-1:0] DEFAULT_DUTY = WIDTH'(1) << (WIDTH - 1);

  logic [ACC_BITS-1:0]   phase_acc_reg;
  logic                  wrap_flag_reg;
  osc_mode_t             active_mode_reg;
  logic [WIDTH-1:0]      active_duty_reg;

  logic [ACC_BITS:0]     phase_sum;
  logic                  wrap_event;
  logic [WIDTH-1:0]      phase_top;
  logic [SHAPE_BITS-1:0] phase_wide;
  logic [SHAPE_BITS-1:0] duty_wide;
  logic [SHAPE_BITS-1:0] shaped_wide;
  logic [WIDTH-1:0]      sample;
  logic [WIDTH:0]        pipe_in;
  logic [WIDTH:0]        pipe_out;

  // The adder carry marks the end of a period, including an exact landing on 0.
  assign phase_sum  = {1'b0, phase_acc_reg} + {1'b0, phase_incr_in};
  assign wrap_event = sync_in | (tick_in & phase_sum[ACC_BITS]);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      phase_acc_reg   <= '0;
      wrap_flag_reg   <= 1'b0;
      active_mode_reg <= PULSE;
      active_duty_reg <= DEFAULT_DUTY;
    end else begin
      if (sync_in) begin
        phase_acc_reg <= '0;
      end else if (tick_in) begin
        phase_acc_reg <= phase_sum[ACC_BITS-1:0];
      end
      wrap_flag_reg <= wrap_event;
      if (wrap_event) begin
        active_mode_reg <= mode_in;
        active_duty_reg <= duty_in;
      end
    end
  end

  assign phase_top   = phase_acc_reg[ACC_BITS-1 -: WIDTH];
  assign phase_wide  = SHAPE_BITS'(phase_top) << (SHAPE_BITS - WIDTH);
  assign duty_wide   = SHAPE_BITS'(active_duty_reg) << (SHAPE_BITS - WIDTH);
  assign shaped_wide = shape_sample(phase_wide, active_mode_reg, duty_wide);
  assign sample      = WIDTH'(shaped_wide >> (SHAPE_BITS - WIDTH));
  assign pipe_in     = {wrap_flag_reg, sample};

  pipeline_ar #(
    .DEPTH (PIPE_DEPTH),
    .WIDTH (WIDTH + 1)
  ) u_pipe (
    .clk (clk_in),
    .rst (rst_in),
    .d   (pipe_in),
    .q   (pipe_out)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      val_out  <= '0;
      wrap_out <= 1'b0;
    end else begin
      val_out  <= pipe_out[WIDTH-1:0];
      wrap_out <= pipe_out[WIDTH];
    end
  end

endmodule

// File: tb/tb_poly_osc.sv
// Scoreboard bench for poly_osc: stimulus pushes expected samples, a monitor
// pops and compares one per clock.
module tb_poly_osc;
  import poly_osc_pkg::*;

  localparam int ACC  = 32;
  localparam int W    = 24;
  localparam int PIPE = 2;
  localparam logic [W-1:0] MAXP = 24'h7FFFFF;
  localparam logic [W-1:0] MINN = 24'h800000;

  logic                clk = 1'b0;
  logic                rst_in = 1'b1;
  logic                tick_in = 1'b0;
  logic                sync_in = 1'b0;
  logic [ACC-1:0]      phase_incr_in = 32'h1000_0000;
  osc_mode_t           mode_in = PULSE;
  logic [W-1:0]        duty_in = 24'h800000;
  logic signed [W-1:0] val_out;
  logic                wrap_out;

  poly_osc #(
    .ACC_BITS   (ACC),
    .WIDTH      (W),
    .PIPE_DEPTH (PIPE)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst_in),
    .tick_in       (tick_in),
    .phase_incr_in (phase_incr_in),
    .mode_in       (mode_in),
    .duty_in       (duty_in),
    .sync_in       (sync_in),
    .val_out       (val_out),
    .wrap_out      (wrap_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] val;
    logic         wrap;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  string cur_test = "init";

  // Reference state: phase, settings and the samples still in flight.
  logic [ACC-1:0] m_phase;
  logic           m_wrap;
  osc_mode_t      m_mode;
  logic [W-1:0]   m_duty;
  exp_t           m_line[PIPE];

  function automatic logic [W-1:0] exp_sample(input logic [W-1:0] p, input osc_mode_t m,
                                               input logic [W-1:0] d);
    int unsigned pv;
    int unsigned r;
    pv = {8'b0, p};
    case (m)
      PULSE: r = (pv < {8'b0, d}) ? 32'h007FFFFF : 32'h00800000;
      SAW:   r = (pv + 32'h00800000) & 32'h00FFFFFF;
      TRI: begin
        if (pv < 32'h00800000) r = ((pv << 1) + 32'h00800000) & 32'h00FFFFFF;
        else r = ((32'h00FFFFFF - ((pv << 1) & 32'h00FFFFFF)) + 32'h00800000) & 32'h00FFFFFF;
      end
      default: r = 32'd0;
    endcase
    return r[W-1:0];
  endfunction

  task automatic model_reset();
    m_phase = '0;
    m_wrap  = 1'b0;
    m_mode  = PULSE;
    m_duty  = 24'h800000;
    for (int i = 0; i < PIPE; i++) begin
      m_line[i].val  = '0;
      m_line[i].wrap = 1'b0;
    end
  endtask

  // Called at a falling edge: drives one cycle, queues the sample expected
  // right after the coming rising edge, then waits for the next falling edge.
  task automatic step(input logic tick, input logic sync);
    exp_t        e;
    logic [ACC:0] sum;
    logic        wev;
    tick_in = tick;
    sync_in = sync;
    e = m_line[PIPE-1];
    for (int i = PIPE - 1; i > 0; i--) m_line[i] = m_line[i-1];
    m_line[0].val  = exp_sample(m_phase[ACC-1 -: W], m_mode, m_duty);
    m_line[0].wrap = m_wrap;
    sb.push_back(e);
    sum = {1'b0, m_phase} + {1'b0, phase_incr_in};
    wev = sync || (tick && sum[ACC]);
    if (sync) m_phase = '0;
    else if (tick) m_phase = sum[ACC-1:0];
    m_wrap = wev;
    if (wev) begin
      m_mode = mode_in;
      m_duty = duty_in;
    end
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [W-1:0] v, input logic w);
    n_checks++;
    if (val_out !== v || wrap_out !== w) begin
      n_fail++;
      $display("FAIL %s: val_out=%h wrap_out=%b, expected val_out=%h wrap_out=%b",
               name, val_out, wrap_out, v, w);
    end
  endtask

  task automatic check_val(input string name, input logic [W-1:0] v);
    n_checks++;
    if (val_out !== v) begin
      n_fail++;
      $display("FAIL %s: val_out=%h, expected %h", name, val_out, v);
    end
  endtask

  task automatic mid_reset();
    #1 rst_in = 1'b1;
    #1 check("async_reset_clears", '0, 1'b0);
    @(negedge clk);
    rst_in = 1'b0;
    model_reset();
  endtask

  // Monitor: one expected sample per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (val_out !== e.val || wrap_out !== e.wrap) begin
          n_fail++;
          $display("FAIL %s sample: val_out=%h wrap_out=%b, expected val_out=%h wrap_out=%b",
                   cur_test, val_out, wrap_out, e.val, e.wrap);
        end else begin
          $display("[%0t] %s val_out=%h wrap_out=%b ok", $time, cur_test, val_out, wrap_out);
        end
      end
    end
  end

  initial begin
    int highs;
    model_reset();
    @(negedge clk);
    check("reset_state", '0, 1'b0);
    rst_in = 1'b0;

    cur_test = "pulse_after_reset";
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 1'b0);
      if (i == 2)  check("pipe_zero_after_reset", '0, 1'b0);
      if (i == 3)  check("first_pulse_high", MAXP, 1'b0);
      if (i == 11) check("pulse_low_half", MINN, 1'b0);
      if (i == 19) check("pulse_new_period", MAXP, 1'b1);
    end

    cur_test = "pulse_mid_reset";
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    mid_reset();
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b0);
      if (i == 3) check("pulse_high_after_mid_reset", MAXP, 1'b0);
    end

    cur_test = "duty_zero";
    duty_in = 24'h000000;
    for (int i = 1; i <= 40; i++) step(1'b1, 1'b0);
    check_val("duty_zero_const_low", MINN);

    cur_test = "duty_quarter";
    duty_in = 24'h400000;
    highs = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 1'b0);
      if (i >= 24 && i <= 39 && val_out === MAXP) highs++;
    end
    n_checks++;
    if (highs != 4) begin
      n_fail++;
      $display("FAIL duty_quarter_high_count: got %0d high samples, expected 4", highs);
    end

    cur_test = "pulse_to_saw";
    duty_in = 24'h800000;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    mode_in = SAW;
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 1'b0);
      if (i >= 20 && wrap_out === 1'b1) check_val("saw_first_sample", 24'h800000);
    end

    cur_test = "tri";
    mode_in = TRI;
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 1'b0);
      if (i >= 20 && wrap_out === 1'b1) check_val("tri_first_sample", 24'h800000);
    end

    cur_test = "sync_tick_low";
    mode_in = MUTE;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("sync_wrap_after_3", '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

    cur_test = "sync_with_tick";
    mode_in = SAW;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b0);
      if (i == 3) check("sync_beats_tick", 24'h800000, 1'b1);
    end

    cur_test = "tick_every_4th";
    for (int i = 0; i < 48; i++) step((i % 4) == 0, 1'b0);

    cur_test = "zero_incr";
    phase_incr_in = '0;
    mode_in = TRI;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);

    cur_test = "exact_wrap_to_zero";
    phase_incr_in = 32'h8000_0000;
    step(1'b0, 1'b1);
    mode_in = PULSE;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);

    cur_test = "drain";
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d samples left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
